mac_grp_tx_time_stamp: RTL and testbench
========================================

Name: mac_grp_tx_time_stamp

Overview:
- Transmit-side PTP timestamp unit. Sits on the GMII TX byte stream of one MAC port, between the TX queue and the MAC.
- Latches the free-running time counter at the first byte of every outgoing frame. Parses the Ethernet/PTP header to qualify PTP event messages (ethertype 0x88F7, messageType < 4).
- For each qualified frame, pushes {messageType, sequenceId, timestamp} into a small first-word-fall-through (FWFT) FIFO read by the register/host logic.

Parameters:
- COUNTER_WIDTH, 64, width of counter_val; must be 64.
- FIFO_AW, 2, FIFO address bits; depth = 2**FIFO_AW entries (4).
- PTP_ETHERTYPE, 16'h88F7, ethertype that qualifies a frame.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  GMII TX byte
- tx_en  in  1  byte valid; high for the whole frame including preamble/SFD
- counter_val  in  COUNTER_WIDTH  free-running time counter
- ts_valid  out  1  FIFO non-empty; head entry is on the ts_* outputs
- ts_rd  in  1  pop head entry; ignored when ts_valid=0
- ts_time_hi  out  32  head timestamp [63:32]
- ts_time_lo  out  32  head timestamp [31:0]
- ts_seq_id  out  16  head PTP sequenceId
- ts_msg_type  out  4  head PTP messageType
- drop_count  out  16  saturating count of qualified frames lost to a full FIFO

Behaviour:
- Byte indexing: index 0 is the first tx_en-high byte of a frame (first preamble byte).
  - Ethertype: byte 20 = high byte, byte 21 = low byte (network order).
  - Byte 22: low nibble is messageType.
  - sequenceId: byte 52 = high byte, byte 53 = low byte.
- The frame byte counter is 7 bits and saturates at 53; it never wraps.
- FSM states: SKIP, IDLE, PARSE. Reset state is SKIP.
  - SKIP: stay while tx_en=1; go to IDLE when tx_en=0. This guarantees a frame already in progress at reset release is never parsed.
  - IDLE: on tx_en=1, latch counter_val into ts_latch, set idx=1, go to PARSE.
  - PARSE, tx_en=0 before byte 53: go to IDLE and discard the frame (truncated; no entry, no drop_count change).
  - PARSE, tx_en=1: consume byte at idx, then idx+1.
  - PARSE, idx=21: if {byte20, byte21} != PTP_ETHERTYPE, go to SKIP.
  - PARSE, idx=22: if tx_data[3:0] >= 4, go to SKIP. Otherwise store msg_type = tx_data[3:0].
  - PARSE, idx=53: issue write request {msg_type, {byte52, byte53}, ts_latch}, then go to SKIP. The bytes after 53 are ignored.
- Back-to-back frames need only one tx_en-low cycle between them.
- Timestamp is counter_val sampled on the clk edge at which byte 0 is present. It is captured by the unit, so the latency to counter_val is 0 cycles.
- FIFO: depth 2**FIFO_AW, FWFT.
  - A written entry is visible (ts_valid=1, outputs updated) the cycle after the byte-53 edge.
  - ts_rd with ts_valid=1 pops on that edge; the next entry (or ts_valid=0) appears the following cycle.
  - Write while full with no pop: entry dropped, drop_count += 1, saturating at 16'hFFFF.
  - Write while full with ts_rd=1 in the same cycle: pop and write both succeed; no drop.
  - Write while empty with ts_rd=1 in the same cycle: ts_rd ignored; entry stored.
- Pointers are FIFO_AW+1 bits; full/empty are distinguished by the MSB.
- ts_* outputs are 0 whenever ts_valid=0.
- Reset values:
  - ts_valid, ts_time_hi, ts_time_lo, ts_seq_id, ts_msg_type, drop_count = 0.
  - FIFO emptied; FSM = SKIP; idx = 0; ts_latch = 0.
- Reset mid-frame: the frame is lost and no entry is written. The next frame that starts after tx_en has been low for at least one cycle is parsed normally.

Test Plan:
- Sync frame (ethertype 0x88F7, byte22=0x00, seq 0x1234), counter_val = 64'h0000_0001_0000_0010 at byte 0 → one entry: ts_time_hi=0x1, ts_time_lo=0x10, seq=0x1234, type=0. ts_valid rises the cycle after byte 53.
- IPv4 frame (ethertype 0x0800), then a Follow_Up frame (byte22=0x08) → no entries; ts_valid stays 0; drop_count=0.
- Delay_Req (type 1) with tx_en dropped after byte 40, then a valid Pdelay_Req (type 2, seq 0x0007) after a 1-cycle gap → exactly one entry: type=2, seq=0x0007.
- Five qualified frames with no reads → 4 entries in order; drop_count=1. Sixth frame written with ts_rd=1 on the same edge → no drop; drop_count stays 1; head advances to entry 2.
- Drain FIFO with ts_rd held high → four consecutive pops, then ts_valid=0 with outputs 0. Extra ts_rd while empty → no effect.
- Assert reset at byte 30 of a Sync frame and release while tx_en is still high → no entry. The following Sync frame (seq 0x00FF) is captured correctly.

Source files
------------

// File: rtl/mac_grp_tx_time_stamp_if.sv
// Timestamp FIFO read port of the TX PTP timestamp unit.
// The unit drives the head entry; the host side pops it with ts_rd.
interface mac_grp_tx_time_stamp_if;
    logic        ts_valid;
    logic        ts_rd;
    logic [31:0] ts_time_hi;
    logic [31:0] ts_time_lo;
    logic [15:0] ts_seq_id;
    logic [3:0]  ts_msg_type;

    modport master (
        output ts_valid,
        output ts_time_hi,
        output ts_time_lo,
        output ts_seq_id,
        output ts_msg_type,
        input  ts_rd
    );

    modport slave (
        input  ts_valid,
        input  ts_time_hi,
        input  ts_time_lo,
        input  ts_seq_id,
        input  ts_msg_type,
        output ts_rd
    );
endinterface

// File: rtl/mac_grp_tx_time_stamp.sv
// TX PTP timestamp unit: latches the time counter at frame start, qualifies
// PTP event messages from the GMII byte stream and queues them in a FWFT FIFO.
module mac_grp_tx_time_stamp #(
    parameter int          COUNTER_WIDTH = 64,
    parameter int          FIFO_AW       = 2,
    parameter logic [15:0] PTP_ETHERTYPE = 16'h88F7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               tx_data,
    input  logic                     tx_en,
    input  logic [COUNTER_WIDTH-1:0] counter_val,
    mac_grp_tx_time_stamp_if.master  ts,
    output logic [15:0]              drop_count
);

    localparam logic [1:0] SKIP  = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] PARSE = 2'd2;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = 4 + 16 + COUNTER_WIDTH;

    logic [1:0]               state;
    logic [6:0]               idx;
    logic [COUNTER_WIDTH-1:0] ts_latch;
    logic [7:0]               eth_hi;
    logic [7:0]               seq_hi;
    logic [3:0]               msg_type;

    logic                     wr_req;
    logic [EW-1:0]            wr_data;

    assign wr_req  = (state == PARSE) && tx_en && (idx == 7'd53);
    assign wr_data = {msg_type, seq_hi, tx_data, ts_latch};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SKIP;
            idx      <= 7'd0;
            ts_latch <= '0;
            eth_hi   <= 8'd0;
            seq_hi   <= 8'd0;
            msg_type <= 4'd0;
        end else begin
            unique case (state)
                SKIP: begin
                    if (!tx_en) state <= IDLE;
                end
                IDLE: begin
                    if (tx_en) begin
                        ts_latch <= counter_val;
                        idx      <= 7'd1;
                        state    <= PARSE;
                    end
                end
                PARSE: begin
                    if (!tx_en) begin
                        // truncated frame: discard silently
                        state <= IDLE;
                        idx   <= 7'd0;
                    end else begin
                        if (idx != 7'd53) idx <= idx + 7'd1;
                        case (idx)
                            7'd20: eth_hi <= tx_data;
                            7'd21: begin
                                if ({eth_hi, tx_data} != PTP_ETHERTYPE)
                                    state <= SKIP;
                            end
                            7'd22: begin
                                msg_type <= tx_data[3:0];
                                if (tx_data[3:0] >= 4'd4) state <= SKIP;
                            end
                            7'd52: seq_hi <= tx_data;
                            7'd53: state  <= SKIP;
                            default: ;
                        endcase
                    end
                end
                default: state <= SKIP;
            endcase
        end
    end

    logic [EW-1:0]    mem [DEPTH];
    logic [FIFO_AW:0] wptr;
    logic [FIFO_AW:0] rptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [EW-1:0]    head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign pop   = ts.ts_rd && !empty;
    // a pop on the same edge frees the slot the write needs
    assign push  = wr_req && (!full || pop);
    assign drop  = wr_req && full && !pop;
    assign head  = mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wptr[FIFO_AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            drop_count <= 16'd0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    assign ts.ts_valid    = !empty;
    assign ts.ts_msg_type = empty ? 4'd0  : head[EW-1 -: 4];
    assign ts.ts_seq_id   = empty ? 16'd0 : head[EW-5 -: 16];
    assign ts.ts_time_hi  = empty ? 32'd0 : head[63:32];
    assign ts.ts_time_lo  = empty ? 32'd0 : head[31:0];

endmodule

// File: tb/tb_mac_grp_tx_time_stamp.sv
// Bench for the TX PTP timestamp unit: directed frames, expected entries
// queued at stimulus time and checked by a monitor on every FIFO pop.
module tb_mac_grp_tx_time_stamp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_en = 1'b0;
    logic [63:0] counter_val = 64'd0;
    logic [15:0] drop_count;

    mac_grp_tx_time_stamp_if tsif ();

    mac_grp_tx_time_stamp dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .counter_val (counter_val),
        .ts          (tsif.master),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [83:0] sb [$];

    task automatic chk(input string name, input logic [83:0] act,
                       input logic [83:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // monitor: every pop handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && tsif.ts_valid && tsif.ts_rd) begin
            logic [83:0] got;
            got = {tsif.ts_msg_type, tsif.ts_seq_id,
                   tsif.ts_time_hi, tsif.ts_time_lo};
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop: got %h, expected none", got);
            end else begin
                chk("pop_entry", got, sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] fb(input int i, input logic [15:0] et,
                                      input logic [7:0] b22,
                                      input logic [15:0] seq);
        logic [7:0] v;
        if (i < 7)        v = 8'h55;
        else if (i == 7)  v = 8'hD5;
        else if (i == 20) v = et[15:8];
        else if (i == 21) v = et[7:0];
        else if (i == 22) v = b22;
        else if (i == 52) v = seq[15:8];
        else if (i == 53) v = seq[7:0];
        else              v = 8'(i) ^ 8'hA5;
        return v;
    endfunction

    task automatic send_frame(input logic [15:0] et, input logic [7:0] b22,
                              input logic [15:0] seq, input int len,
                              input logic [63:0] t0, input bit rd53,
                              input bit chk_lat, input int rst_at);
        for (int i = 0; i < len; i++) begin
            tx_en       = 1'b1;
            tx_data     = fb(i, et, b22, seq);
            counter_val = t0 + 64'(i);
            tsif.ts_rd  = rd53 && (i == 53);
            reset       = (rst_at >= 0) && (i == rst_at || i == rst_at + 1);
            if (chk_lat && i == 53) begin
                @(negedge clk);
                chk("valid_before_53", 84'(tsif.ts_valid), 84'd0);
            end
            if (chk_lat && i == 54) begin
                @(negedge clk);
                chk("valid_after_53", 84'(tsif.ts_valid), 84'd1);
            end
            @(posedge clk);
            #1;
        end
        tx_en      = 1'b0;
        tx_data    = 8'd0;
        tsif.ts_rd = 1'b0;
        reset      = 1'b0;
        counter_val = counter_val + 64'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic read_n(input int n);
        tsif.ts_rd = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        tsif.ts_rd = 1'b0;
    endtask

    task automatic chk_empty(input string name);
        @(negedge clk);
        chk(name, {19'd0, tsif.ts_valid, tsif.ts_msg_type, tsif.ts_seq_id,
                   tsif.ts_time_hi, tsif.ts_time_lo}, 84'd0);
    endtask

    initial begin
        tsif.ts_rd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {tsif.ts_valid, tsif.ts_msg_type, tsif.ts_seq_id,
                              tsif.ts_time_hi, tsif.ts_time_lo},
            84'd0);
        chk("reset_drop", 84'(drop_count), 84'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Sync frame with latency check
        sb.push_back({4'd0, 16'h1234, 64'h0000_0001_0000_0010});
        send_frame(16'h88F7, 8'h00, 16'h1234, 60,
                   64'h0000_0001_0000_0010, 0, 1, -1);
        read_n(1);
        chk_empty("empty_after_sync");

        // IPv4 and Follow_Up: nothing queued
        send_frame(16'h0800, 8'h00, 16'h5555, 64, 64'h100, 0, 0, -1);
        send_frame(16'h88F7, 8'h08, 16'h6666, 64, 64'h200, 0, 0, -1);
        chk_empty("no_entry_nonevent");
        chk("drop_nonevent", 84'(drop_count), 84'd0);

        // truncated Delay_Req then Pdelay_Req after one idle cycle
        send_frame(16'h88F7, 8'h01, 16'h0011, 41, 64'h300, 0, 0, -1);
        sb.push_back({4'd2, 16'h0007, 64'h0000_0000_0000_00AA});
        send_frame(16'h88F7, 8'h02, 16'h0007, 60, 64'hAA, 0, 0, -1);
        @(negedge clk);
        chk("pdelay_valid", 84'(tsif.ts_valid), 84'd1);
        @(posedge clk);
        #1;
        read_n(1);
        chk_empty("empty_after_pdelay");

        // fill: five frames, fifth dropped
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4)
                sb.push_back({4'(k & 3), 16'h0100 + 16'(k),
                              64'h1000_0000_0000_0000 + 64'(k * 16'h1000)});
            send_frame(16'h88F7, 8'(k & 3), 16'h0100 + 16'(k), 60,
                       64'h1000_0000_0000_0000 + 64'(k * 16'h1000),
                       0, 0, -1);
        end
        @(negedge clk);
        chk("drop_after_5", 84'(drop_count), 84'd1);
        chk("head_after_5", 84'(tsif.ts_seq_id), 84'h0101);
        @(posedge clk);
        #1;

        // sixth frame with a pop on the byte-53 edge
        sb.push_back({4'd3, 16'h0106, 64'h2000_0000_0000_6000});
        send_frame(16'h88F7, 8'h03, 16'h0106, 60,
                   64'h2000_0000_0000_6000, 1, 0, -1);
        @(negedge clk);
        chk("drop_after_6", 84'(drop_count), 84'd1);
        chk("head_after_6", 84'(tsif.ts_seq_id), 84'h0102);
        @(posedge clk);
        #1;

        // drain, with extra reads while empty
        read_n(7);
        chk_empty("empty_after_drain");
        chk("drop_after_drain", 84'(drop_count), 84'd1);
        chk("sb_drained", 84'(sb.size()), 84'd0);

        // reset mid-frame, then a normal Sync
        send_frame(16'h88F7, 8'h00, 16'h0055, 60, 64'h3000, 0, 0, 30);
        chk_empty("no_entry_after_reset");
        chk("drop_after_reset", 84'(drop_count), 84'd0);
        @(posedge clk);
        #1;
        sb.push_back({4'd0, 16'h00FF, 64'hDEAD_BEEF_0000_0001});
        send_frame(16'h88F7, 8'h00, 16'h00FF, 60,
                   64'hDEAD_BEEF_0000_0001, 0, 0, -1);
        read_n(1);
        chk_empty("empty_at_end");
        chk("sb_empty_end", 84'(sb.size()), 84'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
